// File: rtl/rvv_pkg.sv
// Shared encodings, types and helpers for the vector-op sequencer.
package rvv_pkg;

  localparam int VLEN       = 128;
  localparam int VLEN_BYTES = VLEN / 8;
  localparam int NREG       = 32;
  localparam int ALU_LAT    = 2;

  localparam logic [2:0] SEW8      = 3'd0;
  localparam logic [2:0] SEW16     = 3'd1;
  localparam logic [2:0] SEW32     = 3'd2;
  localparam logic [2:0] SEW64     = 3'd3;

  localparam logic [2:0] LMUL1     = 3'd0;
  localparam logic [2:0] LMUL2     = 3'd1;
  localparam logic [2:0] LMUL4     = 3'd2;
  localparam logic [2:0] LMUL8     = 3'd3;
  localparam logic [2:0] LMUL_RSVD = 3'd4;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ERR, ZERO} state_t;

  // One beat travelling down the ID->EX pipeline towards writeback.
  typedef struct packed {
    logic                  last;
    logic [2:0]            idx;
    logic [VLEN_BYTES-1:0] be;
  } wb_beat_t;

  // Register group size G; fractional LMUL still occupies one register.
  function automatic logic [3:0] lmul_regs(input logic [2:0] enc);
    case (enc)
      LMUL2:   return 4'd2;
      LMUL4:   return 4'd4;
      LMUL8:   return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  // log2 of element size in bytes (only meaningful for legal encodings).
  function automatic logic [1:0] sew_shift(input logic [2:0] enc);
    return enc[1:0];
  endfunction

  // Byte enables for a partial final beat: low rem bytes written.
  function automatic logic [VLEN_BYTES-1:0] tail_be(input logic [3:0] rem);
    logic [VLEN_BYTES-1:0] be;
    be = '0;
    for (int i = 0; i < VLEN_BYTES; i++) be[i] = (4'(i) < rem);
    return be;
  endfunction

endpackage

// File: rtl/rvv_wb_delay.sv
// Fixed-latency delay line carrying issued beats to the writeback point.
module rvv_wb_delay
  import rvv_pkg::*;
#(
  parameter int STAGES = ALU_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     vld_i,
  input  wb_beat_t beat_i,
  output logic     vld_o,
  output wb_beat_t beat_o
);

  logic [STAGES:1] vld_pipe;
  wb_beat_t        beat_pipe [STAGES:1];

  // Shift valid and beat payload one stage per cycle; reset drops in-flight beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) beat_pipe[s] <= '0;
    end else begin
      vld_pipe[1]  <= vld_i;
      beat_pipe[1] <= beat_i;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        beat_pipe[s] <= beat_pipe[s-1];
      end
    end
  end

  assign vld_o  = vld_pipe[STAGES];
  assign beat_o = beat_pipe[STAGES];

endmodule

// File: rtl/rvv_vop_sequencer.sv
// Splits one vector ALU instruction into per-register beats over its LMUL
// group, drives regfile reads / vALU operands, and times the writebacks.
module rvv_vop_sequencer
  import rvv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_vs1,
  input  logic [4:0]  in_vs2,
  input  logic [4:0]  in_vd,
  input  logic [31:0] in_scalar,
  input  logic [8:0]  vl,
  input  logic [6:0]  vtype,
  output logic [4:0]  raA,
  output logic [4:0]  raB,
  output logic [2:0]  valu_op,
  output logic [31:0] alu_scalar,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [15:0] wb_be,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_q;
  logic [2:0]  k_q;
  logic [3:0]  beats_q;
  logic [3:0]  rem_q;
  logic        tail_q;
  logic [4:0]  vd_q;
  logic [4:0]  raA_q, raB_q;
  logic [2:0]  op_q;
  logic [31:0] scalar_q;

  // Accept-time decode of vtype / vl / register alignment.
  logic [2:0]  sew_enc, lmul_enc;
  logic [3:0]  grp;
  logic [4:0]  gmask;
  logic        vt_ok, al_ok, capped;
  logic [11:0] bytes;
  logic [8:0]  nbeats;
  logic [3:0]  beats_d;
  logic        tail_d;

  assign sew_enc  = vtype[5:3];
  assign lmul_enc = vtype[2:0];
  assign grp      = lmul_regs(lmul_enc);
  assign gmask    = 5'(grp - 4'd1);
  assign vt_ok    = vtype[6] && (sew_enc <= SEW64) && (lmul_enc != LMUL_RSVD);
  assign al_ok    = ((in_vs1 | in_vs2 | in_vd) & gmask) == 5'd0;
  assign bytes    = {3'b000, vl} << sew_shift(sew_enc);
  assign nbeats   = 9'((13'(bytes) + 13'd15) >> 4);
  assign capped   = nbeats > {5'd0, grp};
  assign beats_d  = capped ? grp : nbeats[3:0];
  // When vl overruns the group the last beat is a full register, so the
  // tail mask only applies when the byte count actually ends inside it.
  assign tail_d   = !capped && (bytes[3:0] != 4'd0);

  // Beat currently being issued, fed into the writeback delay line.
  logic     issue_vld, issue_last;
  wb_beat_t beat_in;
  logic     wb_vld;
  wb_beat_t wb_beat;

  assign issue_vld  = (state_q == ISSUE);
  assign issue_last = ({1'b0, k_q} == (beats_q - 4'd1));

  // Assemble the per-beat writeback descriptor.
  always_comb begin
    beat_in      = '0;
    beat_in.last = issue_last;
    beat_in.idx  = k_q;
    beat_in.be   = (issue_last && tail_q) ? tail_be(rem_q) : '1;
  end

  rvv_wb_delay #(.STAGES(ALU_LAT)) u_wb_delay (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue_vld),
    .beat_i (beat_in),
    .vld_o  (wb_vld),
    .beat_o (wb_beat)
  );

  // Sequencer FSM: latch on accept, step read addresses per beat, drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      beats_q  <= '0;
      rem_q    <= '0;
      tail_q   <= 1'b0;
      vd_q     <= '0;
      raA_q    <= '0;
      raB_q    <= '0;
      op_q     <= '0;
      scalar_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            scalar_q <= in_scalar;
            vd_q     <= in_vd;
            raA_q    <= in_vs2;
            raB_q    <= in_vs1;
            k_q      <= '0;
            beats_q  <= beats_d;
            rem_q    <= bytes[3:0];
            tail_q   <= tail_d;
            if (!vt_ok || !al_ok)    state_q <= ERR;
            else if (beats_d == 4'd0) state_q <= ZERO;
            else                      state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_last) begin
            state_q <= DRAIN;
          end else begin
            k_q   <= k_q + 3'd1;
            raA_q <= raA_q + 5'd1;
            raB_q <= raB_q + 5'd1;
          end
        end
        DRAIN: begin
          if (wb_vld && wb_beat.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign err        = (state_q == ERR);
  assign done       = (state_q == ZERO) || (wb_vld && wb_beat.last);
  assign raA        = raA_q;
  assign raB        = raB_q;
  assign valu_op    = op_q;
  assign alu_scalar = scalar_q;
  assign wb_en      = wb_vld;
  assign wb_addr    = wb_vld ? (vd_q + {2'b00, wb_beat.idx}) : 5'd0;
  assign wb_be      = wb_vld ? wb_beat.be : 16'd0;

endmodule
